pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: the sequencer is the master, the memory the slave.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch / execute / halt / trap control for a single-issue core.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master imem,
  input  logic           exec_done,
  input  logic           nextPCSrc,
  input  logic [31:0]    branch_target,
  input  logic           halt_req,
  output logic [31:0]    pc,
  output logic [31:0]    inst,
  output logic           inst_valid,
  output logic           halted,
  output logic           trap,
  output logic [1:0]     trap_cause,
  output logic [31:0]    retired_cnt,
  output logic [31:0]    taken_cnt
);

  localparam int unsigned      WAIT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [1:0]          cause_q, cause_d;
  logic [31:0]         retired_q, retired_d;
  logic [31:0]         taken_q, taken_d;
  logic [31:0]         target;

  // Jump targets are halfword-addressed by the ALU; bit 0 is always dropped.
  function automatic logic [31:0] taken_target(input logic [31:0] t);
    return t & 32'hFFFF_FFFE;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] t);
    return t[1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    wait_d    = '0;
    cause_d   = cause_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    target    = taken_target(branch_target);

    case (state_q)
      S_IDLE: begin
        state_d = halt_req ? S_HALT : S_FETCH;
      end

      // The wait counter is zero on every entry to FETCH since it only survives here.
      S_FETCH: begin
        if (imem.imem_ready) begin
          inst_d  = imem.imem_rdata;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          if (nextPCSrc && is_misaligned(target)) begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end else begin
            pc_d      = nextPCSrc ? target : pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            if (nextPCSrc) begin
              taken_d = taken_q + 32'd1;
            end
            state_d = halt_req ? S_HALT : S_FETCH;
          end
        end
      end

      S_HALT: begin
        if (!halt_req) begin
          state_d = S_FETCH;
        end
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = (state_q == S_EXEC);
  assign halted         = (state_q == S_HALT);
  assign trap           = (state_q == S_TRAP);
  assign trap_cause     = cause_q;
  assign retired_cnt    = retired_q;
  assign taken_cnt      = taken_q;

  a_trap_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    state_q == S_TRAP |=> state_q == S_TRAP);

  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    imem.imem_req && !imem.imem_ready |=> $stable(imem.imem_addr));

  a_status_excl : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({inst_valid, halted, trap, imem.imem_req}));

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: acts as memory and datapath, checks against a transaction-level model.
module tb_pc_sequencer;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
  localparam int          TIMEOUT     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_done;
  logic        nextPCSrc;
  logic [31:0] branch_target;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;

  pc_sequencer_if imem_bus ();

  pc_sequencer #(
    .RESET_PC      (TB_RESET_PC),
    .FETCH_TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus.master),
    .exec_done     (exec_done),
    .nextPCSrc     (nextPCSrc),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .halted        (halted),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .retired_cnt   (retired_cnt),
    .taken_cnt     (taken_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural view of the sequencer: where it is, what it has retired.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_taken;
  logic [1:0]  m_cause;
  bit          m_trapped;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_noise;
    exec_done     = 1'($urandom_range(0, 1));
    nextPCSrc     = 1'($urandom_range(0, 1));
    branch_target = $urandom;
    halt_req      = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input bit hold_halt);
    int k;
    rst_n               = 1'b0;
    exec_done           = 1'b0;
    imem_bus.imem_ready = 1'b0;
    halt_req            = hold_halt;
    #2;
    chk_eq("rst_pc",        pc,                 TB_RESET_PC);
    chk_eq("rst_addr",      imem_bus.imem_addr, TB_RESET_PC);
    chk_eq("rst_inst",      inst,               32'h0);
    chk_eq("rst_req",       imem_bus.imem_req,  32'h0);
    chk_eq("rst_valid",     inst_valid,         32'h0);
    chk_eq("rst_halted",    halted,             32'h0);
    chk_eq("rst_trap",      trap,               32'h0);
    chk_eq("rst_cause",     trap_cause,         32'h0);
    chk_eq("rst_retired",   retired_cnt,        32'h0);
    chk_eq("rst_taken",     taken_cnt,          32'h0);
    m_pc      = TB_RESET_PC;
    m_ret     = 32'h0;
    m_taken   = 32'h0;
    m_cause   = 2'b00;
    m_trapped = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_eq("idle_req", imem_bus.imem_req, 32'h0);
    tick;
    if (hold_halt) begin
      chk_eq("idle_to_halt", halted, 32'h1);
      chk_eq("halt_no_req",  imem_bus.imem_req, 32'h0);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        tick;
        chk_eq("halt_hold", halted, 32'h1);
      end
      halt_req = 1'b0;
      tick;
      chk_eq("halt_release", halted, 32'h0);
    end
    chk_eq("first_fetch_req",  imem_bus.imem_req,  32'h1);
    chk_eq("first_fetch_addr", imem_bus.imem_addr, TB_RESET_PC);
  endtask

  task automatic run_timeout;
    imem_bus.imem_ready = 1'b0;
    chk_eq("to_start_req", imem_bus.imem_req, 32'h1);
    for (int i = 1; i < TIMEOUT; i++) begin
      rand_noise();
      tick;
      chk_eq("to_wait_req",  imem_bus.imem_req,  32'h1);
      chk_eq("to_wait_addr", imem_bus.imem_addr, m_pc);
      chk_eq("to_wait_trap", trap,               32'h0);
    end
    tick;
    m_trapped = 1'b1;
    m_cause   = 2'b10;
    chk_eq("to_trap",  trap,              32'h1);
    chk_eq("to_cause", trap_cause,        m_cause);
    chk_eq("to_req",   imem_bus.imem_req, 32'h0);
    chk_eq("to_pc",    pc,                m_pc);
    exec_done = 1'b0;
    halt_req  = 1'b0;
  endtask

  // abort_mode: 0 = complete, 1 = reset during FETCH, 2 = reset during EXEC.
  task automatic do_instr(input int abort_mode, input bit rnd, input bit f_nps,
                          input logic [31:0] f_tgt, input bit f_halt);
    logic [31:0] data;
    logic [31:0] tgt;
    logic [31:0] tgt_al;
    bit          nps;
    bit          hlt;
    int          d;
    int          e;
    int          k;

    chk_eq("fetch_req",  imem_bus.imem_req,  32'h1);
    chk_eq("fetch_addr", imem_bus.imem_addr, m_pc);

    d = $urandom_range(0, TIMEOUT - 1);
    for (int i = 0; i < d; i++) begin
      imem_bus.imem_ready = 1'b0;
      rand_noise();
      tick;
      chk_eq("fetch_hold_req",  imem_bus.imem_req,  32'h1);
      chk_eq("fetch_hold_addr", imem_bus.imem_addr, m_pc);
      chk_eq("fetch_no_valid",  inst_valid,         32'h0);
    end
    if (abort_mode == 1) begin
      do_reset(1'b0);
      return;
    end

    data                = $urandom;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = data;
    rand_noise();
    exec_done = 1'b0;
    tick;
    imem_bus.imem_ready = 1'b0;
    chk_eq("exec_valid", inst_valid,        32'h1);
    chk_eq("exec_inst",  inst,              data);
    chk_eq("exec_req",   imem_bus.imem_req, 32'h0);
    chk_eq("exec_pc",    pc,                m_pc);
    if (abort_mode == 2) begin
      do_reset(1'b0);
      return;
    end

    e = $urandom_range(0, 4);
    for (int i = 0; i < e; i++) begin
      rand_noise();
      exec_done           = 1'b0;
      imem_bus.imem_ready = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = $urandom;
      tick;
      chk_eq("exec_hold_valid", inst_valid, 32'h1);
      chk_eq("exec_hold_inst",  inst,       data);
    end

    if (rnd) begin
      nps    = 1'($urandom_range(0, 1));
      tgt    = $urandom;
      tgt[1] = ($urandom_range(0, 11) == 0);
      hlt    = ($urandom_range(0, 3) == 0);
    end else begin
      nps = f_nps;
      tgt = f_tgt;
      hlt = f_halt;
    end
    exec_done           = 1'b1;
    nextPCSrc           = nps;
    branch_target       = tgt;
    halt_req            = hlt;
    imem_bus.imem_ready = 1'($urandom_range(0, 1));
    tick;
    exec_done           = 1'b0;
    imem_bus.imem_ready = 1'b0;

    tgt_al = {tgt[31:1], 1'b0};
    if (nps && tgt_al[1]) begin
      m_trapped = 1'b1;
      m_cause   = 2'b01;
      halt_req  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk_eq("mis_trap",  trap,              32'h1);
        chk_eq("mis_cause", trap_cause,        m_cause);
        chk_eq("mis_pc",    pc,                m_pc);
        chk_eq("mis_req",   imem_bus.imem_req, 32'h0);
        chk_eq("mis_valid", inst_valid,        32'h0);
        rand_noise();
        imem_bus.imem_ready = 1'($urandom_range(0, 1));
        tick;
      end
      chk_eq("mis_sticky", trap, 32'h1);
      exec_done = 1'b0;
      halt_req  = 1'b0;
      return;
    end

    m_pc  = nps ? tgt_al : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    if (nps) m_taken = m_taken + 32'd1;
    chk_eq("retire_pc",      pc,          m_pc);
    chk_eq("retire_cnt",     retired_cnt, m_ret);
    chk_eq("retire_taken",   taken_cnt,   m_taken);
    chk_eq("retire_novalid", inst_valid,  32'h0);
    chk_eq("retire_halted",  halted,      32'(hlt));

    if (hlt) begin
      chk_eq("halt_req_low", imem_bus.imem_req, 32'h0);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        tick;
        chk_eq("halt_stay", halted, 32'h1);
      end
      halt_req = 1'b0;
      tick;
      chk_eq("halt_exit", halted, 32'h0);
    end
    halt_req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int r;
    rst_n               = 1'b1;
    exec_done           = 1'b0;
    nextPCSrc           = 1'b0;
    branch_target       = 32'h0;
    halt_req            = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    #1;
    do_reset(1'b0);

    // Wrap from 0xFFFF_FFFC, then 0,4,8; taken branch at 8 to 0x101 -> 0x100.
    do_instr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b0, 1'b1, 32'h0000_0101, 1'b0);
    chk_eq("branch_addr", imem_bus.imem_addr, 32'h0000_0100);
    do_instr(0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_eq("resume_addr", imem_bus.imem_addr, 32'h0000_0104);
    do_instr(0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
    do_reset(1'b1);
    run_timeout();
    do_reset(1'b0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(2, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    do_instr(1, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if (m_trapped) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        r = $urandom_range(0, 39);
        if (r == 0) run_timeout();
        else if (r == 1) do_instr($urandom_range(1, 2), 1'b1, 1'b0, 32'h0, 1'b0);
        else do_instr(0, 1'b1, 1'b0, 32'h0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
